// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage MIPS core: widths, control-bundle bit
// positions and the NOP encoding.
package cpu_pkg;

    localparam int DW   = 32;
    localparam int CTRW = 9;

    // Control bundle, MSB first: {RegWrite, MemtoReg, MemWrite, MemRead, ALUSrc, RegDst, ALUControl[2:0]}
    localparam int CTL_REGWRITE = 8;
    localparam int CTL_MEMTOREG = 7;
    localparam int CTL_MEMWRITE = 6;
    localparam int CTL_MEMREAD  = 5;
    localparam int CTL_ALUSRC   = 4;
    localparam int CTL_REGDST   = 3;
    localparam int CTL_ALUCTL   = 0;
    localparam int CTL_ALUCTL_W = 3;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: requests a stall when the load in EX writes a
// register that the instruction in decode reads.
module hazard_detect #(
    parameter int DW = 32
) (
    input  logic          i_validE,
    input  logic          i_mem_readE,
    input  logic [4:0]    i_rtE,
    input  logic          i_validD,
    input  logic [DW-1:0] i_instrD,
    input  logic          i_flush,
    input  logic          i_hold,
    output logic          o_stall_req
);

    logic w_src_match;
    logic w_load_in_ex;

    // Compare the load destination against both decode source fields.
    always_comb begin
        w_src_match  = (i_rtE == i_instrD[25:21]) || (i_rtE == i_instrD[20:16]);
        w_load_in_ex = i_validE && i_mem_readE && (i_rtE != 5'd0);
        if (i_flush || i_hold) begin
            o_stall_req = 1'b0;
        end else begin
            o_stall_req = w_load_in_ex && i_validD && w_src_match;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decode operands and control, inserts
// bubbles on flush or load-use, and counts bubbles with a saturating counter.
module id_ex_stage #(
    parameter int DW   = cpu_pkg::DW,
    parameter int CTRW = cpu_pkg::CTRW,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            hold,
    input  logic            validD,
    input  logic [DW-1:0]   instrD,
    input  logic [DW-1:0]   pcD,
    input  logic [DW-1:0]   rsdataD,
    input  logic [DW-1:0]   rtdataD,
    input  logic [DW-1:0]   immD,
    input  logic [CTRW-1:0] ctrlD,
    output logic            validE,
    output logic [DW-1:0]   instrE,
    output logic [DW-1:0]   pcE,
    output logic [DW-1:0]   rsdataE,
    output logic [DW-1:0]   rtdataE,
    output logic [DW-1:0]   immE,
    output logic [CTRW-1:0] ctrlE,
    output logic [4:0]      rsE,
    output logic [4:0]      rtE,
    output logic [4:0]      rdE,
    output logic            stall_req,
    output logic [CNTW-1:0] bubble_cnt
);

    import cpu_pkg::*;

    logic            r_valid;
    logic [CTRW-1:0] r_ctrl;
    logic [DW-1:0]   r_instr;
    logic [DW-1:0]   r_pc;
    logic [DW-1:0]   r_rsdata;
    logic [DW-1:0]   r_rtdata;
    logic [DW-1:0]   r_imm;
    logic [CNTW-1:0] r_bubble_cnt;
    logic            w_stall;
    logic            w_bubble;

    hazard_detect #(
        .DW (DW)
    ) u_hazard (
        .i_validE    (r_valid),
        .i_mem_readE (r_ctrl[CTL_MEMREAD]),
        .i_rtE       (r_instr[20:16]),
        .i_validD    (validD),
        .i_instrD    (instrD),
        .i_flush     (flush),
        .i_hold      (hold),
        .o_stall_req (w_stall)
    );

    // A bubble is inserted only when EX is not frozen; flush and stall collapse into one.
    always_comb begin
        if (hold) begin
            w_bubble = 1'b0;
        end else begin
            w_bubble = flush || w_stall;
        end
    end

    // Valid, control and instruction word: hold, bubble, or load from decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= {CTRW{1'b0}};
            r_instr <= NOP_INSTR[DW-1:0];
        end else if (hold) begin
            r_valid <= r_valid;
            r_ctrl  <= r_ctrl;
            r_instr <= r_instr;
        end else if (w_bubble) begin
            r_valid <= 1'b0;
            r_ctrl  <= {CTRW{1'b0}};
            r_instr <= NOP_INSTR[DW-1:0];
        end else begin
            r_valid <= validD;
            r_ctrl  <= validD ? ctrlD : {CTRW{1'b0}};
            r_instr <= instrD;
        end
    end

    // Data operands load whenever EX advances; their content is irrelevant in a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= {DW{1'b0}};
            r_rsdata <= {DW{1'b0}};
            r_rtdata <= {DW{1'b0}};
            r_imm    <= {DW{1'b0}};
        end else if (!hold) begin
            r_pc     <= pcD;
            r_rsdata <= rsdataD;
            r_rtdata <= rtdataD;
            r_imm    <= immD;
        end else begin
            r_pc     <= r_pc;
            r_rsdata <= r_rsdata;
            r_rtdata <= r_rtdata;
            r_imm    <= r_imm;
        end
    end

    // Saturating bubble counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= {CNTW{1'b0}};
        end else if (w_bubble && (r_bubble_cnt != {CNTW{1'b1}})) begin
            r_bubble_cnt <= r_bubble_cnt + {{(CNTW-1){1'b0}}, 1'b1};
        end else begin
            r_bubble_cnt <= r_bubble_cnt;
        end
    end

    assign validE     = r_valid;
    assign ctrlE      = r_ctrl;
    assign instrE     = r_instr;
    assign pcE        = r_pc;
    assign rsdataE    = r_rsdata;
    assign rtdataE    = r_rtdata;
    assign immE       = r_imm;
    assign rsE        = r_instr[25:21];
    assign rtE        = r_instr[20:16];
    assign rdE        = r_instr[15:11];
    assign stall_req  = w_stall;
    assign bubble_cnt = r_bubble_cnt;

endmodule
